// File: rtl/gte_writeback_commit_if.sv
// Write-back bundle from the GTE compute path plus CPU write port and committed register view.
// master drives the strobes/values; slave (the commit stage) drives the architectural registers.
interface gte_writeback_commit_if;
  logic        i_start;
  logic        i_last;
  logic        i_wrMAC0;
  logic        i_wrIR0;
  logic        i_wrOTZ;
  logic        i_wrMAC13;
  logic        i_wrIR13;
  logic [1:0]  i_sel;
  logic        i_pushX;
  logic        i_pushY;
  logic        i_pushZ;
  logic        i_wrCol;
  logic        i_pushRGB;
  logic [31:0] i_MAC0;
  logic [31:0] i_MAC13;
  logic [15:0] i_IR0;
  logic [15:0] i_IR13;
  logic [15:0] i_OTZV;
  logic [15:0] i_XYV;
  logic [7:0]  i_colV;
  logic [7:0]  i_code;
  logic [18:0] i_updateFlags;
  logic        i_cpuWr;
  logic [4:0]  i_cpuAddr;
  logic [31:0] i_cpuData;

  logic        o_busy;
  logic        o_done;
  logic [31:0] o_FLAG;
  logic [31:0] o_MAC0, o_MAC1, o_MAC2, o_MAC3;
  logic [15:0] o_IR0, o_IR1, o_IR2, o_IR3;
  logic [15:0] o_OTZ;
  logic [31:0] o_SXY0, o_SXY1, o_SXY2;
  logic [15:0] o_SZ0, o_SZ1, o_SZ2, o_SZ3;
  logic [31:0] o_RGB0, o_RGB1, o_RGB2;

  modport master (
    output i_start, i_last, i_wrMAC0, i_wrIR0, i_wrOTZ, i_wrMAC13, i_wrIR13, i_sel,
           i_pushX, i_pushY, i_pushZ, i_wrCol, i_pushRGB, i_MAC0, i_MAC13, i_IR0, i_IR13,
           i_OTZV, i_XYV, i_colV, i_code, i_updateFlags, i_cpuWr, i_cpuAddr, i_cpuData,
    input  o_busy, o_done, o_FLAG, o_MAC0, o_MAC1, o_MAC2, o_MAC3, o_IR0, o_IR1, o_IR2, o_IR3,
           o_OTZ, o_SXY0, o_SXY1, o_SXY2, o_SZ0, o_SZ1, o_SZ2, o_SZ3, o_RGB0, o_RGB1, o_RGB2
  );

  modport slave (
    input  i_start, i_last, i_wrMAC0, i_wrIR0, i_wrOTZ, i_wrMAC13, i_wrIR13, i_sel,
           i_pushX, i_pushY, i_pushZ, i_wrCol, i_pushRGB, i_MAC0, i_MAC13, i_IR0, i_IR13,
           i_OTZV, i_XYV, i_colV, i_code, i_updateFlags, i_cpuWr, i_cpuAddr, i_cpuData,
    output o_busy, o_done, o_FLAG, o_MAC0, o_MAC1, o_MAC2, o_MAC3, o_IR0, o_IR1, o_IR2, o_IR3,
           o_OTZ, o_SXY0, o_SXY1, o_SXY2, o_SZ0, o_SZ1, o_SZ2, o_SZ3, o_RGB0, o_RGB1, o_RGB2
  );
endinterface

// File: rtl/gte_writeback_commit.sv
// GTE register commit stage: FLAG accumulation, MAC/IR/OTZ commit, SXY/SZ/RGB FIFOs,
// instruction start/last/done framing and CPU direct-write arbitration. All commits land next cycle.
module gte_writeback_commit (
  input  logic i_clk,
  input  logic i_rst,
  gte_writeback_commit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [18:0] flag_q, flag_d;
  logic [31:0] mac_q [4];
  logic [31:0] mac_d [4];
  logic [15:0] ir_q [4];
  logic [15:0] ir_d [4];
  logic [15:0] otz_q, otz_d;
  logic [15:0] stagex_q, stagex_d;
  logic [31:0] sxy_q [3];
  logic [31:0] sxy_d [3];
  logic [15:0] sz_q [4];
  logic [15:0] sz_d [4];
  logic [7:0]  col_q [3];
  logic [7:0]  col_d [3];
  logic [31:0] rgb_q [3];
  logic [31:0] rgb_d [3];
  logic        cpu_ok;
  logic [15:0] x_byp;
  logic [7:0]  col_byp [3];

  // CPU may only write when no instruction is in flight or being framed this cycle.
  assign cpu_ok = (state_q == IDLE) && !bus.i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.i_start) state_q <= bus.i_last ? DONE : BUSY;
        BUSY: if (bus.i_last) state_q <= DONE;
        DONE: begin
          if (bus.i_start) state_q <= bus.i_last ? DONE : BUSY;
          else             state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    flag_d   = (bus.i_start ? 19'd0 : flag_q) | bus.i_updateFlags;
    mac_d    = mac_q;
    ir_d     = ir_q;
    otz_d    = otz_q;
    sxy_d    = sxy_q;
    sz_d     = sz_q;
    rgb_d    = rgb_q;
    x_byp    = bus.i_pushX ? bus.i_XYV : stagex_q;
    stagex_d = x_byp;
    col_byp  = col_q;

    if (bus.i_wrMAC0) mac_d[0] = bus.i_MAC0;
    if (bus.i_wrIR0)  ir_d[0]  = bus.i_IR0;
    if (bus.i_wrOTZ)  otz_d    = bus.i_OTZV;
    if (bus.i_wrMAC13 && bus.i_sel != 2'd0) mac_d[bus.i_sel] = bus.i_MAC13;
    if (bus.i_wrIR13 && bus.i_sel != 2'd0)  ir_d[bus.i_sel]  = bus.i_IR13;

    if (bus.i_pushY) begin
      sxy_d[0] = sxy_q[1];
      sxy_d[1] = sxy_q[2];
      sxy_d[2] = {bus.i_XYV, x_byp};
    end

    if (bus.i_pushZ) begin
      sz_d[0] = sz_q[1];
      sz_d[1] = sz_q[2];
      sz_d[2] = sz_q[3];
      sz_d[3] = bus.i_OTZV;
    end

    // Channel written this cycle is forwarded into a coincident push.
    if (bus.i_wrCol && bus.i_sel != 2'd0) col_byp[bus.i_sel - 2'd1] = bus.i_colV;
    col_d = col_byp;
    if (bus.i_pushRGB) begin
      rgb_d[0] = rgb_q[1];
      rgb_d[1] = rgb_q[2];
      rgb_d[2] = {bus.i_code, col_byp[2], col_byp[1], col_byp[0]};
    end

    // Register addresses are laid out so the low two bits give the slot index.
    if (bus.i_cpuWr && cpu_ok) begin
      case (bus.i_cpuAddr)
        5'd7:                      otz_d = bus.i_cpuData[15:0];
        5'd8, 5'd9, 5'd10, 5'd11:  ir_d[bus.i_cpuAddr[1:0]] = bus.i_cpuData[15:0];
        5'd12, 5'd13, 5'd14:       sxy_d[bus.i_cpuAddr[1:0]] = bus.i_cpuData;
        5'd15: begin
          sxy_d[0] = sxy_q[1];
          sxy_d[1] = sxy_q[2];
          sxy_d[2] = bus.i_cpuData;
        end
        5'd16, 5'd17, 5'd18, 5'd19: sz_d[bus.i_cpuAddr[1:0]] = bus.i_cpuData[15:0];
        5'd20, 5'd21, 5'd22:        rgb_d[bus.i_cpuAddr[1:0]] = bus.i_cpuData;
        5'd24, 5'd25, 5'd26, 5'd27: mac_d[bus.i_cpuAddr[1:0]] = bus.i_cpuData;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flag_q   <= '0;
      mac_q    <= '{default: '0};
      ir_q     <= '{default: '0};
      otz_q    <= '0;
      stagex_q <= '0;
      sxy_q    <= '{default: '0};
      sz_q     <= '{default: '0};
      col_q    <= '{default: '0};
      rgb_q    <= '{default: '0};
    end else begin
      flag_q   <= flag_d;
      mac_q    <= mac_d;
      ir_q     <= ir_d;
      otz_q    <= otz_d;
      stagex_q <= stagex_d;
      sxy_q    <= sxy_d;
      sz_q     <= sz_d;
      col_q    <= col_d;
      rgb_q    <= rgb_d;
    end
  end

  // flag_q[i] holds FLAG[i+12]; summary covers FLAG[30:23] and FLAG[18:13].
  assign bus.o_FLAG = {(|flag_q[18:11]) | (|flag_q[6:1]), flag_q, 12'd0};
  assign bus.o_busy = (state_q == BUSY) || bus.i_start;
  assign bus.o_done = (state_q == DONE);
  assign bus.o_MAC0 = mac_q[0];
  assign bus.o_MAC1 = mac_q[1];
  assign bus.o_MAC2 = mac_q[2];
  assign bus.o_MAC3 = mac_q[3];
  assign bus.o_IR0  = ir_q[0];
  assign bus.o_IR1  = ir_q[1];
  assign bus.o_IR2  = ir_q[2];
  assign bus.o_IR3  = ir_q[3];
  assign bus.o_OTZ  = otz_q;
  assign bus.o_SXY0 = sxy_q[0];
  assign bus.o_SXY1 = sxy_q[1];
  assign bus.o_SXY2 = sxy_q[2];
  assign bus.o_SZ0  = sz_q[0];
  assign bus.o_SZ1  = sz_q[1];
  assign bus.o_SZ2  = sz_q[2];
  assign bus.o_SZ3  = sz_q[3];
  assign bus.o_RGB0 = rgb_q[0];
  assign bus.o_RGB1 = rgb_q[1];
  assign bus.o_RGB2 = rgb_q[2];

  // The sequencer never stages and commits an SXY pair in the same cycle.
  assert property (@(posedge i_clk) disable iff (i_rst) !(bus.i_pushX && bus.i_pushY));

endmodule

// File: tb/tb_gte_writeback_commit.sv
// Directed bench for gte_writeback_commit: reset, FLAG accumulation, MAC/IR commit, FIFOs,
// start/last/done framing, CPU write arbitration and mid-instruction reset.
module tb_gte_writeback_commit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  gte_writeback_commit_if bus();

  gte_writeback_commit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_start = 0; bus.i_last = 0; bus.i_wrMAC0 = 0; bus.i_wrIR0 = 0; bus.i_wrOTZ = 0;
    bus.i_wrMAC13 = 0; bus.i_wrIR13 = 0; bus.i_sel = 0; bus.i_pushX = 0; bus.i_pushY = 0;
    bus.i_pushZ = 0; bus.i_wrCol = 0; bus.i_pushRGB = 0; bus.i_MAC0 = 0; bus.i_MAC13 = 0;
    bus.i_IR0 = 0; bus.i_IR13 = 0; bus.i_OTZV = 0; bus.i_XYV = 0; bus.i_colV = 0; bus.i_code = 0;
    bus.i_updateFlags = 0; bus.i_cpuWr = 0; bus.i_cpuAddr = 0; bus.i_cpuData = 0;
  endtask

  task automatic cpu_write(input logic [4:0] addr, input logic [31:0] data);
    bus.i_cpuWr = 1; bus.i_cpuAddr = addr; bus.i_cpuData = data;
    tick();
    bus.i_cpuWr = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    chk("rst_flag", bus.o_FLAG, 32'h0);
    chk("rst_mac0", bus.o_MAC0, 32'h0);
    chk("rst_ir1",  {16'h0, bus.o_IR1}, 32'h0);
    chk("rst_sxy2", bus.o_SXY2, 32'h0);
    chk("rst_sz3",  {16'h0, bus.o_SZ3}, 32'h0);
    chk("rst_rgb2", bus.o_RGB2, 32'h0);
    chk("rst_busy", {31'h0, bus.o_busy}, 32'h0);
    chk("rst_done", {31'h0, bus.o_done}, 32'h0);

    // CPU writes while idle
    cpu_write(5'd9, 32'h0000_1234);
    chk("cpu_ir1", {16'h0, bus.o_IR1}, 32'h1234);
    cpu_write(5'd7, 32'hFFFF_0777);
    chk("cpu_otz", {16'h0, bus.o_OTZ}, 32'h0777);
    cpu_write(5'd23, 32'h5555_5555);
    chk("cpu_ign23_rgb2", bus.o_RGB2, 32'h0);

    // FLAG accumulation and summary bit
    bus.i_start = 1; bus.i_updateFlags = 19'(1 << 10);
    #1 chk("busy_start", {31'h0, bus.o_busy}, 32'h1);
    tick();
    chk("flag_c1", bus.o_FLAG, 32'h0040_0000);
    bus.i_start = 0; bus.i_updateFlags = 19'(1 << 1);
    tick();
    chk("flag_c2", bus.o_FLAG, 32'h8040_2000);
    bus.i_last = 1; bus.i_updateFlags = 19'(1 << 7);
    tick();
    chk("flag_c3", bus.o_FLAG, 32'h8048_2000);
    chk("done_1",  {31'h0, bus.o_done}, 32'h1);
    // Back-to-back start in DONE clears FLAG
    bus.i_last = 0; bus.i_start = 1; bus.i_updateFlags = 0;
    #1 chk("busy_in_done", {31'h0, bus.o_busy}, 32'h1);
    tick();
    chk("flag_clr", bus.o_FLAG, 32'h0);
    chk("done_gap", {31'h0, bus.o_done}, 32'h0);
    bus.i_start = 0; bus.i_last = 1; bus.i_updateFlags = 19'(1 << 0);
    tick();
    chk("done_2", {31'h0, bus.o_done}, 32'h1);
    chk("flag_bit12_nosum", bus.o_FLAG, 32'h0000_1000);
    bus.i_last = 0; bus.i_updateFlags = 0;
    tick();
    chk("idle_done", {31'h0, bus.o_done}, 32'h0);
    chk("idle_busy", {31'h0, bus.o_busy}, 32'h0);

    // Handshake, MAC/IR commit and CPU arbitration
    bus.i_start = 1; bus.i_wrMAC0 = 1; bus.i_MAC0 = 32'h0000_ABCD;
    bus.i_wrMAC13 = 1; bus.i_sel = 2'd2; bus.i_MAC13 = 32'h1234_5678;
    bus.i_wrIR13 = 1; bus.i_IR13 = 16'hBEEF;
    tick();
    clear_inputs();
    chk("mac0_commit", bus.o_MAC0, 32'h0000_ABCD);
    chk("mac2_commit", bus.o_MAC2, 32'h1234_5678);
    chk("ir2_commit",  {16'h0, bus.o_IR2}, 32'hBEEF);
    bus.i_wrMAC13 = 1; bus.i_wrIR13 = 1; bus.i_sel = 2'd0;
    bus.i_MAC13 = 32'hFFFF_FFFF; bus.i_IR13 = 16'hFFFF;
    bus.i_cpuWr = 1; bus.i_cpuAddr = 5'd24; bus.i_cpuData = 32'hDEAD_BEEF;
    #1 chk("busy_mid", {31'h0, bus.o_busy}, 32'h1);
    tick();
    clear_inputs();
    chk("cpu_drop_busy", bus.o_MAC0, 32'h0000_ABCD);
    chk("sel0_mac1", bus.o_MAC1, 32'h0);
    chk("sel0_mac2", bus.o_MAC2, 32'h1234_5678);
    chk("sel0_ir3",  {16'h0, bus.o_IR3}, 32'h0);
    chk("no_done_early", {31'h0, bus.o_done}, 32'h0);
    bus.i_last = 1;
    tick();
    bus.i_last = 0;
    chk("done_cycle3", {31'h0, bus.o_done}, 32'h1);
    cpu_write(5'd24, 32'h0000_1111);
    chk("cpu_drop_done", bus.o_MAC0, 32'h0000_ABCD);
    chk("done_pulse_end", {31'h0, bus.o_done}, 32'h0);

    // SXY FIFO
    cpu_write(5'd14, 32'hAAAA_5555);
    bus.i_pushX = 1; bus.i_XYV = 16'h0005;
    tick();
    bus.i_pushX = 0; bus.i_pushY = 1; bus.i_XYV = 16'hFFFB;
    tick();
    bus.i_pushY = 0;
    chk("sxy2_push", bus.o_SXY2, 32'hFFFB_0005);
    chk("sxy1_push", bus.o_SXY1, 32'hAAAA_5555);
    cpu_write(5'd15, 32'h0010_0020);
    chk("sxyp_2", bus.o_SXY2, 32'h0010_0020);
    chk("sxyp_1", bus.o_SXY1, 32'hFFFB_0005);
    chk("sxyp_0", bus.o_SXY0, 32'hAAAA_5555);

    // RGB staging and bypass
    bus.i_wrCol = 1; bus.i_sel = 2'd1; bus.i_colV = 8'h11; tick();
    bus.i_sel = 2'd2; bus.i_colV = 8'h22; tick();
    bus.i_sel = 2'd3; bus.i_colV = 8'h33; tick();
    bus.i_wrCol = 0; bus.i_pushRGB = 1; bus.i_code = 8'h30; tick();
    chk("rgb2_push", bus.o_RGB2, 32'h3033_2211);
    bus.i_wrCol = 1; bus.i_sel = 2'd3; bus.i_colV = 8'h44; tick();
    clear_inputs();
    chk("rgb2_bypass", bus.o_RGB2, 32'h3044_2211);
    chk("rgb1_shift",  bus.o_RGB1, 32'h3033_2211);

    // SZ FIFO, then reset mid-instruction
    bus.i_pushZ = 1; bus.i_OTZV = 16'h0100; tick();
    bus.i_OTZV = 16'h0200; tick();
    bus.i_pushZ = 0;
    chk("sz3_push", {16'h0, bus.o_SZ3}, 32'h0200);
    chk("sz2_push", {16'h0, bus.o_SZ2}, 32'h0100);
    bus.i_start = 1; tick();
    bus.i_start = 0;
    rst = 1; bus.i_pushZ = 1; bus.i_OTZV = 16'h0300; bus.i_last = 1;
    tick();
    rst = 0;
    clear_inputs();
    #1;
    chk("rst_mid_sz3",  {16'h0, bus.o_SZ3}, 32'h0);
    chk("rst_mid_sz2",  {16'h0, bus.o_SZ2}, 32'h0);
    chk("rst_mid_busy", {31'h0, bus.o_busy}, 32'h0);
    chk("rst_mid_done", {31'h0, bus.o_done}, 32'h0);
    chk("rst_mid_mac0", bus.o_MAC0, 32'h0);
    tick();
    chk("rst_mid_nodone", {31'h0, bus.o_done}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
